// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default sizes for the data-memory responder and MEM stage
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int CNT_W = 4;
  localparam int DMEM_DATA_WIDTH = 10;
  localparam int DMEM_ADDR_WIDTH = 10;
  localparam int DMEM_DEPTH = 256;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word array with synchronous write and registered, clearable read
module dmem_array #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH = 256,
  parameter int IW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  input  logic [IW-1:0]         idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // storage write; contents deliberately survive reset
  always_ff @(posedge clk) if (we) mem[idx] <= wdata;
  // read register doubles as the response data; stores and rejected accesses return 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else if (re) rdata_q <= mem[idx];
    else if (clr) rdata_q <= '0;
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: wait-state data-memory target with valid/ready request and response
// Optional feature: define DMEM_BOUNDS_CHECK_EN to reject addresses >= DEPTH instead of wrapping.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  Req_Valid_IN,
  output logic                  Req_Ready_OUT,
  input  logic                  Req_Write_IN,
  input  logic [ADDR_WIDTH-1:0] Req_Address_IN,
  input  logic [DATA_WIDTH-1:0] Req_Data_IN,
  output logic                  Resp_Valid_OUT,
  input  logic                  Resp_Ready_IN,
  output logic [DATA_WIDTH-1:0] Resp_Data_OUT,
  output logic                  Resp_Error_OUT,
  output logic                  Busy_OUT
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, acc_addr;
  logic [DATA_WIDTH-1:0] data_q, data_d, acc_data;
  logic wr_q, wr_d, acc_wr;
  logic ready_q, ready_d, valid_q, valid_d, busy_q, busy_d;
  logic accept, access, in_range;
  assign accept = state_q == IDLE && Req_Valid_IN;
  assign access = LATENCY == 0 ? accept : (state_q == WAIT && cnt_q == CNT_W'(1));
  assign acc_addr = LATENCY == 0 ? Req_Address_IN : addr_q;
  assign acc_data = LATENCY == 0 ? Req_Data_IN : data_q;
  assign acc_wr = LATENCY == 0 ? Req_Write_IN : wr_q;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic err_q, err_d;
  assign in_range = {1'b0, acc_addr} < (ADDR_WIDTH + 1)'(DEPTH);
  assign err_d = access ? !in_range : err_q;
  assign Resp_Error_OUT = err_q;
  // error flag is captured at the access edge and held through the response
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) err_q <= 1'b0;
    else err_q <= err_d;
`else
  logic unused_addr;
  assign in_range = 1'b1;
  assign unused_addr = ^acc_addr;
  assign Resp_Error_OUT = 1'b0;
`endif
  // next-state, counter and request capture
  always_comb begin
    state_d = state_q == IDLE ? (accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
              state_q == WAIT ? (access ? RESP : WAIT) :
              (Resp_Ready_IN ? IDLE : RESP);
    cnt_d = accept ? CNT_W'(LATENCY) : (state_q == WAIT ? cnt_q - 1'b1 : cnt_q);
    addr_d = accept ? Req_Address_IN : addr_q;
    data_d = accept ? Req_Data_IN : data_q;
    wr_d = accept ? Req_Write_IN : wr_q;
    ready_d = state_d == IDLE;
    valid_d = state_d == RESP;
    busy_d = state_d != IDLE;
  end
  // control state and registered handshake outputs
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q <= wr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  assign Req_Ready_OUT = ready_q;
  assign Resp_Valid_OUT = valid_q;
  assign Busy_OUT = busy_q;
  logic arr_we, arr_re;
  assign arr_we = access && acc_wr && in_range;
  assign arr_re = access && !acc_wr && in_range;
  dmem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk(CLK),
    .rst_n(RESET),
    .we(arr_we),
    .re(arr_re),
    .clr(access && !arr_re),
    .idx(acc_addr[IW-1:0]),
    .wdata(acc_data),
    .rdata_q(Resp_Data_OUT)
  );
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: table, corner-case and random checks against a memory model
module tb_data_memory_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [9:0] req_addr = '0, req_data = '0;
  logic req_ready, resp_valid, resp_err, busy;
  logic [9:0] resp_data;
  logic z_valid = 1'b0, z_write = 1'b0, z_resp_ready = 1'b0;
  logic [9:0] z_addr = '0, z_data = '0;
  logic z_ready, z_resp_valid, z_resp_err, z_busy;
  logic [9:0] z_resp_data;
  int tests = 0, fails = 0;
  logic [9:0] model [int];

  always #5 clk = ~clk;

  data_memory_responder #(.LATENCY(2)) dut (
    .CLK(clk), .RESET(rst_n), .Req_Valid_IN(req_valid), .Req_Ready_OUT(req_ready),
    .Req_Write_IN(req_write), .Req_Address_IN(req_addr), .Req_Data_IN(req_data),
    .Resp_Valid_OUT(resp_valid), .Resp_Ready_IN(resp_ready), .Resp_Data_OUT(resp_data),
    .Resp_Error_OUT(resp_err), .Busy_OUT(busy)
  );

  data_memory_responder #(.LATENCY(0)) dut0 (
    .CLK(clk), .RESET(rst_n), .Req_Valid_IN(z_valid), .Req_Ready_OUT(z_ready),
    .Req_Write_IN(z_write), .Req_Address_IN(z_addr), .Req_Data_IN(z_data),
    .Resp_Valid_OUT(z_resp_valid), .Resp_Ready_IN(z_resp_ready), .Resp_Data_OUT(z_resp_data),
    .Resp_Error_OUT(z_resp_err), .Busy_OUT(z_busy)
  );

  typedef struct {
    bit w;
    logic [9:0] a;
    logic [9:0] d;
    logic [9:0] exp_data;
    bit exp_err;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // effective word index of an address, -1 when the request is rejected
  function automatic int eff(input int a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return a < 256 ? a : -1;
`else
    return a % 256;
`endif
  endfunction

  task automatic req(input bit w, input logic [9:0] a, input logic [9:0] d, input int hold,
                     output logic [9:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_data;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_data", resp_data, rd);
      chk("hold_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic zreq(input bit w, input logic [9:0] a, input logic [9:0] d,
                      output logic [9:0] rd, output int lat);
    @(negedge clk);
    z_valid = 1'b1; z_write = w; z_addr = a; z_data = d; z_resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    z_valid = 1'b0;
    lat = 1;
    while (!z_resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = z_resp_data;
    z_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_resp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [9];
    logic [9:0] rd;
    logic er;
    int lat, n, e;
    bit bc;
`ifdef DMEM_BOUNDS_CHECK_EN
    bc = 1'b1;
`else
    bc = 1'b0;
`endif
    tbl[0] = '{1'b1, 10'd5,    10'h155, 10'h000, 1'b0};
    tbl[1] = '{1'b0, 10'd5,    10'h000, 10'h155, 1'b0};
    tbl[2] = '{1'b1, 10'd44,   10'h011, 10'h000, 1'b0};
    tbl[3] = '{1'b1, 10'd300,  10'h3FF, 10'h000, bc};
    tbl[4] = '{1'b0, 10'd44,   10'h000, bc ? 10'h011 : 10'h3FF, 1'b0};
    tbl[5] = '{1'b0, 10'd300,  10'h000, bc ? 10'h000 : 10'h3FF, bc};
    tbl[6] = '{1'b1, 10'd255,  10'h2A5, 10'h000, 1'b0};
    tbl[7] = '{1'b0, 10'd255,  10'h000, 10'h2A5, 1'b0};
    tbl[8] = '{1'b0, 10'd1023, 10'h000, bc ? 10'h000 : 10'h2A5, bc};

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_data", resp_data, 10'h0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 9; i++) begin
      req(tbl[i].w, tbl[i].a, tbl[i].d, 0, rd, er, lat);
      chk($sformatf("tbl%0d_lat", i), lat, 3);
      chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
      chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
      e = eff(int'(tbl[i].a));
      if (tbl[i].w && e >= 0) model[e] = tbl[i].d;
    end

    zreq(1'b1, 10'd5, 10'h155, rd, lat);
    chk("lat0_store_lat", lat, 1);
    chk("lat0_store_data", rd, 10'h0);
    zreq(1'b0, 10'd5, 10'h0, rd, lat);
    chk("lat0_load_lat", lat, 1);
    chk("lat0_load_data", rd, 10'h155);
    chk("lat0_err", z_resp_err, 1'b0);
    chk("lat0_idle", z_busy, 1'b0);

    req(1'b0, 10'd5, 10'h0, 4, rd, er, lat);
    chk("hold_load_data", rd, 10'h155);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd44;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1; req_addr = 10'd9; req_data = 10'h123;
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_lat", n, 3);
    chk("b2b_first_data", resp_data, model[44]);
    repeat (2) begin
      @(negedge clk);
      chk("b2b_wait_ready", req_ready, 1'b0);
      chk("b2b_wait_valid", resp_valid, 1'b1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("b2b_hs_ready", req_ready, 1'b1);
    chk("b2b_hs_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_accept_busy", busy, 1'b1);
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_lat", n, 3);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    model[9] = 10'h123;
    req(1'b0, 10'd9, 10'h0, 0, rd, er, lat);
    chk("b2b_store_landed", rd, 10'h123);

    req(1'b1, 10'd7, 10'h071, 0, rd, er, lat);
    model[7] = 10'h071;
    req(1'b0, 10'd5, 10'h0, 0, rd, er, lat);
    chk("pre_reset_data", rd, 10'h155);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd7; req_data = 10'h0AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_wait_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 1'b1);
    chk("arst_valid", resp_valid, 1'b0);
    chk("arst_data", resp_data, 10'h0);
    chk("arst_err", resp_err, 1'b0);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req(1'b0, 10'd7, 10'h0, 0, rd, er, lat);
    chk("arst_store_dropped", rd, 10'h071);

    for (int i = 0; i < 40; i++) begin
      bit w;
      logic [9:0] a, d;
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
      d = 10'($urandom_range(0, 1023));
      e = eff(int'(a));
      req(w, a, d, 0, rd, er, lat);
      chk("rnd_lat", lat, 3);
      chk("rnd_err", er, e < 0);
      if (w || e < 0) chk("rnd_data_zero", rd, 10'h0);
      else if (model.exists(e)) chk("rnd_load", rd, model[e]);
      if (w && e >= 0) model[e] = d;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
